// File: rtl/gpio_in_pkg.sv
// rtl/gpio_in_pkg.sv - shared constants and latency helper for the GPIO input conditioner
package gpio_in_pkg;

    localparam int SYNC_STAGES_MIN  = 2;
    localparam int SYNC_STAGES_MAX  = 4;
    localparam int DEB_BITS_DEFAULT = 4;

    // Edges from a stable pad change to the new level on in_val; T=0 behaves as T=1.
    function automatic int gpio_latency(input int sync_stages, input int t);
        return sync_stages + ((t < 1) ? 1 : t);
    endfunction

endpackage

// File: rtl/gpio_in_bit.sv
// rtl/gpio_in_bit.sv - one pad bit: synchronizer, debounce counter, edge pulses, pending flag
module gpio_in_bit
    import gpio_in_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DEB_BITS    = DEB_BITS_DEFAULT
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                pad,
    input  logic [DEB_BITS-1:0] deb_threshold,
    input  logic                irq_rise_en,
    input  logic                irq_fall_en,
    input  logic                irq_clr,
    output logic                in_val,
    output logic                rise_pulse,
    output logic                fall_pulse,
    output logic                irq_pending
);

    localparam logic [DEB_BITS-1:0] ONE = DEB_BITS'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [DEB_BITS-1:0]    cnt;
    logic [DEB_BITS-1:0]    t_last;
    logic                   s;
    logic                   accept;
    logic                   irq_set;

    assign s       = sync_q[SYNC_STAGES-1];
    assign t_last  = (deb_threshold == '0) ? '0 : deb_threshold - ONE;
    // >= rather than == so a threshold lowered mid-count still accepts on the next mismatch
    assign accept  = (s != in_val) && (cnt >= t_last);
    assign irq_set = (rise_pulse & irq_rise_en) | (fall_pulse & irq_fall_en);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_q      <= '0;
            cnt         <= '0;
            in_val      <= 1'b0;
            rise_pulse  <= 1'b0;
            fall_pulse  <= 1'b0;
            irq_pending <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pad};

            if (s == in_val) begin
                cnt <= '0;
            end else if (accept) begin
                cnt    <= '0;
                in_val <= s;
            end else begin
                cnt <= cnt + ONE;
            end

            rise_pulse  <= accept & s;
            fall_pulse  <= accept & ~s;
            irq_pending <= (irq_pending & ~irq_clr) | irq_set;
        end
    end

endmodule

// File: rtl/gpio_in_conditioner.sv
// rtl/gpio_in_conditioner.sv - WIDTH-bit pad input conditioner with debounce, edge pulses and IRQ
module gpio_in_conditioner
    import gpio_in_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int DEB_BITS    = DEB_BITS_DEFAULT
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [WIDTH-1:0]    pad_in,
    input  logic [DEB_BITS-1:0] deb_threshold,
    input  logic [WIDTH-1:0]    irq_rise_en,
    input  logic [WIDTH-1:0]    irq_fall_en,
    input  logic [WIDTH-1:0]    irq_clr,
    output logic [WIDTH-1:0]    in_val,
    output logic [WIDTH-1:0]    rise_pulse,
    output logic [WIDTH-1:0]    fall_pulse,
    output logic [WIDTH-1:0]    irq_pending,
    output logic                irq
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        gpio_in_bit #(
            .SYNC_STAGES (SYNC_STAGES),
            .DEB_BITS    (DEB_BITS)
        ) u_bit (
            .clk           (clk),
            .resetn        (resetn),
            .pad           (pad_in[i]),
            .deb_threshold (deb_threshold),
            .irq_rise_en   (irq_rise_en[i]),
            .irq_fall_en   (irq_fall_en[i]),
            .irq_clr       (irq_clr[i]),
            .in_val        (in_val[i]),
            .rise_pulse    (rise_pulse[i]),
            .fall_pulse    (fall_pulse[i]),
            .irq_pending   (irq_pending[i])
        );
    end

    assign irq = |irq_pending;

endmodule

// File: tb/tb_gpio_in_conditioner.sv
// tb/tb_gpio_in_conditioner.sv - randomized and directed self-checking bench for gpio_in_conditioner
module tb_gpio_in_conditioner;
    import gpio_in_pkg::*;

    localparam int W  = 16;
    localparam int SS = 2;
    localparam int DB = 4;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic [W-1:0]  pad_in = '0;
    logic [DB-1:0] deb_threshold = '0;
    logic [W-1:0]  irq_rise_en = '0;
    logic [W-1:0]  irq_fall_en = '0;
    logic [W-1:0]  irq_clr = '0;
    logic [W-1:0]  in_val, rise_pulse, fall_pulse, irq_pending;
    logic          irq;

    int checks = 0;
    int errors = 0;

    gpio_in_conditioner #(.WIDTH(W), .SYNC_STAGES(SS), .DEB_BITS(DB)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .pad_in        (pad_in),
        .deb_threshold (deb_threshold),
        .irq_rise_en   (irq_rise_en),
        .irq_fall_en   (irq_fall_en),
        .irq_clr       (irq_clr),
        .in_val        (in_val),
        .rise_pulse    (rise_pulse),
        .fall_pulse    (fall_pulse),
        .irq_pending   (irq_pending),
        .irq           (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: pad delayed by the synchronizer depth, then a level is accepted
    // once the delayed pad has disagreed with the current level for T consecutive edges.
    logic [W-1:0] pad_hist [SS];
    logic [W-1:0] m_val, m_rise, m_fall, m_pend;
    int           m_run [W];

    always begin
        logic [W-1:0] s_w, nr, nf;
        int           teff;
        @(posedge clk or negedge resetn);
        if (!resetn) begin
            for (int k = 0; k < SS; k++) pad_hist[k] = '0;
            for (int i = 0; i < W; i++) m_run[i] = 0;
            m_val = '0; m_rise = '0; m_fall = '0; m_pend = '0;
        end else begin
            s_w  = pad_hist[SS-1];
            nr   = '0;
            nf   = '0;
            teff = (deb_threshold == 0) ? 1 : int'(deb_threshold);
            for (int i = 0; i < W; i++) begin
                if (s_w[i] != m_val[i]) begin
                    m_run[i]++;
                    if (m_run[i] >= teff) begin
                        m_val[i] = s_w[i];
                        m_run[i] = 0;
                        if (s_w[i]) nr[i] = 1'b1;
                        else        nf[i] = 1'b1;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            m_pend = (m_pend & ~irq_clr) | (m_rise & irq_rise_en) | (m_fall & irq_fall_en);
            m_rise = nr;
            m_fall = nf;
            for (int k = SS - 1; k > 0; k--) pad_hist[k] = pad_hist[k-1];
            pad_hist[0] = pad_in;
        end
    end

    always begin
        @(negedge clk);
        check("in_val",      32'(in_val),      32'(m_val));
        check("rise_pulse",  32'(rise_pulse),  32'(m_rise));
        check("fall_pulse",  32'(fall_pulse),  32'(m_fall));
        check("irq_pending", 32'(irq_pending), 32'(m_pend));
        check("irq",         32'(irq),         32'(|m_pend));
    end

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Counts negedges until in_val[idx] reaches value; 999 marks a timeout.
    task automatic measure_latency(input int idx, input logic value, output int n);
        n = 999;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (in_val[idx] == value) begin
                n = i;
                break;
            end
        end
        if (n != 999) begin
            if (value) check("edge_rise_with_level", 32'(rise_pulse[idx]), 32'd1);
            else       check("edge_fall_with_level", 32'(fall_pulse[idx]), 32'd1);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int lat;

        deb_threshold = 4'd3;
        wait_cycles(3);
        check("reset_in_val", 32'(in_val), 32'd0);
        check("reset_irq",    32'(irq),    32'd0);
        resetn = 1'b1;
        wait_cycles(3);

        // bit 0 rise with T=3
        pad_in[0] = 1'b1;
        measure_latency(0, 1'b1, lat);
        check("lat_bit0_t3", 32'(lat), 32'(gpio_latency(SS, 3)));
        check("others_unchanged", 32'(in_val), 32'h0001);
        @(negedge clk);
        check("rise0_one_cycle", 32'(rise_pulse[0]), 32'd0);

        // glitch of 3 cycles on bit 5 with T=4 must be rejected
        deb_threshold = 4'd4;
        wait_cycles(4);
        pad_in[5] = 1'b1;
        wait_cycles(3);
        pad_in[5] = 1'b0;
        wait_cycles(10);
        check("glitch_bit5", 32'(in_val[5]), 32'd0);

        // T=0 behaves as T=1
        deb_threshold = 4'd0;
        wait_cycles(4);
        pad_in[2] = 1'b1;
        measure_latency(2, 1'b1, lat);
        check("lat_bit2_t0", 32'(lat), 32'(gpio_latency(SS, 1)));
        deb_threshold = 4'd1;
        wait_cycles(4);
        pad_in[2] = 1'b0;
        measure_latency(2, 1'b0, lat);
        check("lat_bit2_t1", 32'(lat), 32'd3);

        // falling-edge interrupt on bit 7, clear colliding with a new set
        irq_fall_en[7] = 1'b1;
        deb_threshold  = 4'd2;
        pad_in[7] = 1'b1;
        wait_cycles(10);
        pad_in[7] = 1'b0;
        measure_latency(7, 1'b0, lat);
        @(negedge clk);
        check("pend7_set", 32'(irq_pending[7]), 32'd1);
        check("irq_set",   32'(irq),            32'd1);
        pad_in[7] = 1'b1;
        wait_cycles(10);
        pad_in[7] = 1'b0;
        measure_latency(7, 1'b0, lat);
        irq_clr[7] = 1'b1;
        @(negedge clk);
        irq_clr[7] = 1'b0;
        check("pend7_set_wins", 32'(irq_pending[7]), 32'd1);
        wait_cycles(2);
        irq_clr[7] = 1'b1;
        @(negedge clk);
        irq_clr[7] = 1'b0;
        check("pend7_cleared", 32'(irq_pending[7]), 32'd0);
        check("irq_cleared",   32'(irq),            32'd0);

        // reset in the middle of a count on bit 3 with T=5
        deb_threshold = 4'd5;
        wait_cycles(4);
        pad_in[3] = 1'b1;
        wait_cycles(4);
        #2 resetn = 1'b0;
        #1;
        check("async_rst_in_val", 32'(in_val),      32'd0);
        check("async_rst_pend",   32'(irq_pending), 32'd0);
        check("async_rst_irq",    32'(irq),         32'd0);
        wait_cycles(2);
        resetn = 1'b1;
        measure_latency(3, 1'b1, lat);
        check("lat_bit3_after_rst", 32'(lat), 32'(gpio_latency(SS, 5)));

        // lower T from 8 to 2 while bit 9 has counted 5 mismatches
        deb_threshold = 4'd8;
        wait_cycles(12);
        pad_in[9] = 1'b1;
        wait_cycles(SS + 5);
        check("bit9_still_low", 32'(in_val[9]), 32'd0);
        deb_threshold = 4'd2;
        @(negedge clk);
        check("bit9_accept_on_lower_t", 32'(in_val[9]), 32'd1);
        check("bit9_rise",              32'(rise_pulse[9]), 32'd1);

        // randomized traffic
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 3) == 0)
                pad_in[$urandom_range(0, W - 1)] ^= 1'b1;
            if ($urandom_range(0, 63) == 0)
                deb_threshold = DB'($urandom_range(0, 6));
            if (c % 100 == 0) begin
                irq_rise_en = W'($urandom);
                irq_fall_en = W'($urandom);
            end
            irq_clr = ($urandom_range(0, 15) == 0) ? W'($urandom) : '0;
        end
        irq_clr = '0;
        wait_cycles(20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
